fetch_ctrl: RTL and testbench

- Producer side of the fetch-to-decode instruction queue.
- Generates the sequential fetch PC and issues FETCH_WIDTH-wide requests to the ICache.
- Tracks in-flight requests and holds returned packets until the instruction buffer accepts them.
- Drives {pc, icache_dout, icache_dout_val} into the buffer under its inst_buffer_rdy backpressure; redirect discards stale in-flight responses.

---
 rtl/fetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: producer side of the fetch-to-decode instruction queue.
// Generates the sequential fetch PC, issues FETCH_WIDTH-wide ICache requests,
// tracks in-flight requests with a credit scheme, and holds returned packets
// until the instruction buffer accepts them. A redirect reloads the PC,
// flushes held packets and drains stale in-flight responses.
// Optional build macro: FETCH_CTRL_PERF_EN adds three saturating perf counters
// (perf_req_cnt, perf_drop_cnt, perf_bp_cnt).
module fetch_ctrl #(
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32,
  parameter int FETCH_WIDTH   = 2,
  parameter int MAX_INFLIGHT  = 2,
  parameter logic [CPU_ADDR_BITS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 redirect_val,
  input  logic [CPU_ADDR_BITS-1:0]             redirect_pc,
  output logic                                 icache_req_val,
  input  logic                                 icache_req_rdy,
  output logic [CPU_ADDR_BITS-1:0]             icache_req_addr,
  input  logic                                 icache_resp_val,
  input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_resp_data,
  output logic [CPU_ADDR_BITS-1:0]             pc,
  output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout,
  output logic                                 icache_dout_val,
  input  logic                                 inst_buffer_rdy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]                          perf_req_cnt,
  output logic [31:0]                          perf_drop_cnt,
  output logic [31:0]                          perf_bp_cnt
`endif
);

  localparam int PKT_BITS = FETCH_WIDTH * CPU_INST_BITS;
  localparam int PTR_W    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W    = $clog2(MAX_INFLIGHT + 1);
  localparam int SUM_W    = CNT_W + 1;

  localparam logic [CPU_ADDR_BITS-1:0] PC_STRIDE = CPU_ADDR_BITS'(FETCH_WIDTH * 4);
  localparam logic [CPU_ADDR_BITS-1:0] ALIGN_MASK = ~(CPU_ADDR_BITS'(3));
  localparam logic [PTR_W-1:0]         PTR_LAST  = PTR_W'(MAX_INFLIGHT - 1);
  localparam logic [SUM_W-1:0]         CREDITS   = SUM_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Circular pointer advance; works for any depth, not only powers of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Architectural state
  state_e                     state_q, state_d;
  logic [CPU_ADDR_BITS-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]           outstanding_q, outstanding_d;
  logic [CNT_W-1:0]           held_q, held_d;
  logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;

  // PC FIFO: addresses of accepted, not yet answered requests
  logic [CPU_ADDR_BITS-1:0]   pc_mem_q [MAX_INFLIGHT];
  logic [CPU_ADDR_BITS-1:0]   pc_mem_d [MAX_INFLIGHT];
  logic [PTR_W-1:0]           pc_wr_ptr_q, pc_wr_ptr_d;
  logic [PTR_W-1:0]           pc_rd_ptr_q, pc_rd_ptr_d;

  // Response FIFO: returned packets paired with their PC, waiting for the buffer
  logic [CPU_ADDR_BITS-1:0]   rsp_pc_mem_q [MAX_INFLIGHT];
  logic [CPU_ADDR_BITS-1:0]   rsp_pc_mem_d [MAX_INFLIGHT];
  logic [PKT_BITS-1:0]        rsp_data_mem_q [MAX_INFLIGHT];
  logic [PKT_BITS-1:0]        rsp_data_mem_d [MAX_INFLIGHT];
  logic [PTR_W-1:0]           rsp_wr_ptr_q, rsp_wr_ptr_d;
  logic [PTR_W-1:0]           rsp_rd_ptr_q, rsp_rd_ptr_d;

  // Per-cycle events
  logic [SUM_W-1:0]           credit_sum_s;
  logic                       req_val_s;
  logic                       accept_s;
  logic                       resp_take_s;
  logic                       resp_push_s;
  logic                       resp_drop_s;
  logic                       dout_val_s;
  logic                       pop_s;

  // Decode this cycle's handshakes; a response with nothing outstanding is ignored.
  always_comb begin
    credit_sum_s = {1'b0, outstanding_q} + {1'b0, held_q};
    req_val_s    = (state_q == ST_RUN) && !redirect_val && (credit_sum_s < CREDITS);
    accept_s     = req_val_s && icache_req_rdy;
    resp_take_s  = icache_resp_val && (outstanding_q != '0);
    resp_push_s  = resp_take_s && (state_q == ST_RUN) && !redirect_val;
    resp_drop_s  = resp_take_s && !resp_push_s;
    dout_val_s   = (held_q != '0) && !redirect_val;
    pop_s        = dout_val_s && inst_buffer_rdy;
  end

  // Counters move by their net change; redirect flushes held packets and
  // arms drop_cnt with whatever is still in flight after this cycle.
  always_comb begin
    outstanding_d = outstanding_q;
    held_d        = held_q;
    drop_cnt_d    = drop_cnt_q;

    if (accept_s && !resp_take_s) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (!accept_s && resp_take_s) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end else begin
      outstanding_d = outstanding_q;
    end

    if (redirect_val) begin
      held_d = '0;
    end else if (resp_push_s && !pop_s) begin
      held_d = held_q + CNT_ONE;
    end else if (!resp_push_s && pop_s) begin
      held_d = held_q - CNT_ONE;
    end else begin
      held_d = held_q;
    end

    if (redirect_val) begin
      // no accept is possible here, so this equals outstanding_d
      drop_cnt_d = resp_take_s ? (outstanding_q - CNT_ONE) : outstanding_q;
    end else if ((state_q == ST_DRAIN) && resp_take_s) begin
      drop_cnt_d = drop_cnt_q - CNT_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Next-state logic; DRAIN is entered only when stale responses remain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_val && (drop_cnt_d != '0)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drop_cnt_d == '0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Fetch PC: reload on redirect (word aligned), otherwise advance on accept.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_val) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if (accept_s) begin
      fetch_pc_d = fetch_pc_q + PC_STRIDE;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // PC FIFO update: write on accept, read when a response is kept.
  always_comb begin
    pc_mem_d    = pc_mem_q;
    pc_wr_ptr_d = pc_wr_ptr_q;
    pc_rd_ptr_d = pc_rd_ptr_q;
    if (redirect_val) begin
      pc_wr_ptr_d = '0;
      pc_rd_ptr_d = '0;
    end else begin
      if (accept_s) begin
        pc_mem_d[pc_wr_ptr_q] = fetch_pc_q;
        pc_wr_ptr_d           = next_ptr(pc_wr_ptr_q);
      end else begin
        pc_wr_ptr_d = pc_wr_ptr_q;
      end
      if (resp_push_s) begin
        pc_rd_ptr_d = next_ptr(pc_rd_ptr_q);
      end else begin
        pc_rd_ptr_d = pc_rd_ptr_q;
      end
    end
  end

  // Response FIFO update: push kept responses with their PC, pop on buffer accept.
  always_comb begin
    rsp_pc_mem_d   = rsp_pc_mem_q;
    rsp_data_mem_d = rsp_data_mem_q;
    rsp_wr_ptr_d   = rsp_wr_ptr_q;
    rsp_rd_ptr_d   = rsp_rd_ptr_q;
    if (redirect_val) begin
      rsp_wr_ptr_d = '0;
      rsp_rd_ptr_d = '0;
    end else begin
      if (resp_push_s) begin
        rsp_pc_mem_d[rsp_wr_ptr_q]   = pc_mem_q[pc_rd_ptr_q];
        rsp_data_mem_d[rsp_wr_ptr_q] = icache_resp_data;
        rsp_wr_ptr_d                 = next_ptr(rsp_wr_ptr_q);
      end else begin
        rsp_wr_ptr_d = rsp_wr_ptr_q;
      end
      if (pop_s) begin
        rsp_rd_ptr_d = next_ptr(rsp_rd_ptr_q);
      end else begin
        rsp_rd_ptr_d = rsp_rd_ptr_q;
      end
    end
  end

  // State and FIFO registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      held_q        <= '0;
      drop_cnt_q    <= '0;
      pc_wr_ptr_q   <= '0;
      pc_rd_ptr_q   <= '0;
      rsp_wr_ptr_q  <= '0;
      rsp_rd_ptr_q  <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        pc_mem_q[i]       <= '0;
        rsp_pc_mem_q[i]   <= '0;
        rsp_data_mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      outstanding_q  <= outstanding_d;
      held_q         <= held_d;
      drop_cnt_q     <= drop_cnt_d;
      pc_wr_ptr_q    <= pc_wr_ptr_d;
      pc_rd_ptr_q    <= pc_rd_ptr_d;
      rsp_wr_ptr_q   <= rsp_wr_ptr_d;
      rsp_rd_ptr_q   <= rsp_rd_ptr_d;
      pc_mem_q       <= pc_mem_d;
      rsp_pc_mem_q   <= rsp_pc_mem_d;
      rsp_data_mem_q <= rsp_data_mem_d;
    end
  end

  // Output drive: packet fields are zero whenever nothing valid is presented.
  always_comb begin
    icache_req_val  = req_val_s;
    icache_req_addr = fetch_pc_q;
    icache_dout_val = dout_val_s;
    if (dout_val_s) begin
      pc          = rsp_pc_mem_q[rsp_rd_ptr_q];
      icache_dout = rsp_data_mem_q[rsp_rd_ptr_q];
    end else begin
      pc          = '0;
      icache_dout = '0;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_req_cnt_q,  perf_req_cnt_d;
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;
  logic [31:0] perf_bp_cnt_q,   perf_bp_cnt_d;

  // Saturating event counters; unaffected by redirect.
  always_comb begin
    perf_req_cnt_d  = perf_req_cnt_q;
    perf_drop_cnt_d = perf_drop_cnt_q;
    perf_bp_cnt_d   = perf_bp_cnt_q;
    if (accept_s && (perf_req_cnt_q != 32'hFFFF_FFFF)) begin
      perf_req_cnt_d = perf_req_cnt_q + 32'd1;
    end else begin
      perf_req_cnt_d = perf_req_cnt_q;
    end
    if (resp_drop_s && (perf_drop_cnt_q != 32'hFFFF_FFFF)) begin
      perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
    end else begin
      perf_drop_cnt_d = perf_drop_cnt_q;
    end
    if (dout_val_s && !inst_buffer_rdy && (perf_bp_cnt_q != 32'hFFFF_FFFF)) begin
      perf_bp_cnt_d = perf_bp_cnt_q + 32'd1;
    end else begin
      perf_bp_cnt_d = perf_bp_cnt_q;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_req_cnt_q  <= 32'd0;
      perf_drop_cnt_q <= 32'd0;
      perf_bp_cnt_q   <= 32'd0;
    end else begin
      perf_req_cnt_q  <= perf_req_cnt_d;
      perf_drop_cnt_q <= perf_drop_cnt_d;
      perf_bp_cnt_q   <= perf_bp_cnt_d;
    end
  end

  assign perf_req_cnt  = perf_req_cnt_q;
  assign perf_drop_cnt = perf_drop_cnt_q;
  assign perf_bp_cnt   = perf_bp_cnt_q;
`else
  // Drop events only feed the optional perf counters.
  logic unused_drop_s;
  assign unused_drop_s = resp_drop_s;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a behavioural ICache
// (fixed latency, in-order) and an expected-packet queue toward the buffer.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_val = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        icache_req_val;
  logic        icache_req_rdy = 1'b0;
  logic [31:0] icache_req_addr;
  logic        icache_resp_val = 1'b0;
  logic [63:0] icache_resp_data = 64'h0;
  logic [31:0] pc;
  logic [63:0] icache_dout;
  logic        icache_dout_val;
  logic        inst_buffer_rdy = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_req_cnt, perf_drop_cnt, perf_bp_cnt;
`endif

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc),
    .icache_req_val(icache_req_val), .icache_req_rdy(icache_req_rdy),
    .icache_req_addr(icache_req_addr),
    .icache_resp_val(icache_resp_val), .icache_resp_data(icache_resp_data),
    .pc(pc), .icache_dout(icache_dout), .icache_dout_val(icache_dout_val),
    .inst_buffer_rdy(inst_buffer_rdy)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_req_cnt(perf_req_cnt), .perf_drop_cnt(perf_drop_cnt), .perf_bp_cnt(perf_bp_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [63:0] data; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] del_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit req_rdy_s = 1'b1;
  bit buf_rdy_s = 1'b1;
  bit redir_s = 1'b0;
  logic [31:0] redir_pc_s = 32'h0;
  logic        obs_req_val;
  logic [31:0] obs_req_addr;
  logic        obs_dout_val;

  function automatic logic [63:0] mkdata(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h2468_ACE0, a ^ 32'h1357_9BDF};
  endfunction

  // One clock cycle: drive at negedge, sample #1 later, update models.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      icache_resp_val  = 1'b1;
      icache_resp_data = mkdata(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      icache_resp_val  = 1'b0;
      icache_resp_data = 64'h0;
    end
    icache_req_rdy  = req_rdy_s;
    inst_buffer_rdy = buf_rdy_s;
    redirect_val    = redir_s;
    redirect_pc     = redir_pc_s;
    #1;
    obs_req_val  = icache_req_val;
    obs_req_addr = icache_req_addr;
    obs_dout_val = icache_dout_val;
    if (redirect_val) exp_q.delete();
    if (icache_dout_val && inst_buffer_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h data=%h, expected no packet", pc, icache_dout);
      end else begin
        e = exp_q.pop_front();
        if (pc !== e.pc || icache_dout !== e.data) begin
          errors++;
          $display("FAIL sb_packet got pc=%h data=%h, expected pc=%h data=%h",
                   pc, icache_dout, e.pc, e.data);
        end
      end
      del_q.push_back(pc);
    end else if (!icache_dout_val) begin
      checks++;
      if (pc !== 32'h0 || icache_dout !== 64'h0) begin
        errors++;
        $display("FAIL idle_zero got pc=%h data=%h, expected 0", pc, icache_dout);
      end
    end
    if (icache_req_val && icache_req_rdy) begin
      pend.push_back('{addr: icache_req_addr, due: cyc + lat});
      exp_q.push_back('{pc: icache_req_addr, data: mkdata(icache_req_addr)});
      acc_q.push_back(icache_req_addr);
    end
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_val = 1'b0; icache_req_rdy = 1'b0; icache_resp_val = 1'b0;
    icache_resp_data = 64'h0; inst_buffer_rdy = 1'b0; redirect_pc = 32'h0;
    pend.delete(); exp_q.delete(); acc_q.delete(); del_q.delete();
    req_rdy_s = 1'b1; buf_rdy_s = 1'b1; redir_s = 1'b0; redir_pc_s = 32'h0; lat = 1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (icache_req_val !== 1'b0 || icache_dout_val !== 1'b0 || pc !== 32'h0 ||
        icache_dout !== 64'h0 || icache_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got req_val=%b dout_val=%b pc=%h dout=%h addr=%h, expected all 0",
               icache_req_val, icache_dout_val, pc, icache_dout, icache_req_addr);
    end
    release_reset();
    tick();
    checks++;
    if (obs_req_val !== 1'b0) begin
      errors++; $display("FAIL boot_no_req got req_val=%b, expected 0", obs_req_val);
    end
    tick();
    checks++;
    if (obs_req_val !== 1'b1 || obs_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req got val=%b addr=%h, expected 1 / 00000000", obs_req_val, obs_req_addr);
    end
  endtask

  task automatic test_sequential();
    repeat (12) tick();
    checks++;
    if (acc_q.size() < 4 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h8 ||
        acc_q[2] !== 32'h10 || acc_q[3] !== 32'h18) begin
      errors++; $display("FAIL seq_addrs got %0d accepts, expected 0,8,10,18 first", acc_q.size());
    end
    checks++;
    if (del_q.size() < 2 || del_q[0] !== 32'h0 || del_q[1] !== 32'h8) begin
      errors++; $display("FAIL seq_deliver got %0d deliveries, expected pc 0 then 8", del_q.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    release_reset();
    buf_rdy_s = 1'b0;
    repeat (10) tick();
    checks++;
    if (acc_q.size() != 2 || obs_req_val !== 1'b0) begin
      errors++;
      $display("FAIL bp_credit got %0d accepts req_val=%b, expected 2 accepts req_val=0",
               acc_q.size(), obs_req_val);
    end
    buf_rdy_s = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() < 3; i++) tick();
    checks++;
    if (acc_q.size() < 3 || acc_q[2] !== 32'h10) begin
      errors++; $display("FAIL bp_resume got %0d accepts, expected third addr 00000010", acc_q.size());
    end
    checks++;
    if (del_q.size() < 2 || del_q[0] !== 32'h0 || del_q[1] !== 32'h8) begin
      errors++; $display("FAIL bp_deliver got %0d deliveries, expected pc 0 then 8", del_q.size());
    end
  endtask

  task automatic test_redirect_drain();
    int n0;
    apply_reset();
    lat = 3;
    release_reset();
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    redir_s = 1'b1; redir_pc_s = 32'h0000_1003;
    tick();
    redir_s = 1'b0;
    n0 = acc_q.size();
    for (int i = 0; i < 30 && acc_q.size() == n0; i++) tick();
    checks++;
    if (acc_q.size() == n0 || acc_q[n0] !== 32'h1000 || pend.size() != 1) begin
      errors++;
      $display("FAIL drain_restart got %0d new accepts pend=%0d, expected addr 00001000 after both drops",
               acc_q.size() - n0, pend.size());
    end
    for (int i = 0; i < 30 && del_q.size() == 0; i++) tick();
    checks++;
    if (del_q.size() == 0 || del_q[0] !== 32'h1000) begin
      errors++; $display("FAIL drain_first_pc got %0d deliveries, expected pc 00001000", del_q.size());
    end
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    if (perf_drop_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_drop got %0d, expected 2", perf_drop_cnt);
    end
`endif
  endtask

  task automatic test_redirect_collide();
    apply_reset();
    lat = 2;
    buf_rdy_s = 1'b0;
    release_reset();
    for (int i = 0; i < 20 && !(pend.size() == 1 && acc_q.size() == 2 && pend[0].due <= cyc); i++) tick();
    buf_rdy_s = 1'b1;
    redir_s = 1'b1; redir_pc_s = 32'h0000_2000;
    tick();
    redir_s = 1'b0;
    checks++;
    if (icache_resp_val !== 1'b1 || obs_dout_val !== 1'b0) begin
      errors++;
      $display("FAIL collide_dout got resp_val=%b dout_val=%b, expected 1 / 0", icache_resp_val, obs_dout_val);
    end
    tick();
    checks++;
    if (obs_req_val !== 1'b1 || obs_req_addr !== 32'h2000) begin
      errors++;
      $display("FAIL collide_reissue got val=%b addr=%h, expected 1 / 00002000", obs_req_val, obs_req_addr);
    end
    repeat (6) tick();
    checks++;
    if (del_q.size() == 0 || del_q[0] !== 32'h2000) begin
      errors++; $display("FAIL collide_deliver got %0d deliveries, expected pc 00002000", del_q.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    release_reset();
    tick();
    redir_s = 1'b1; redir_pc_s = 32'hFFFF_FFF8;
    tick();
    redir_s = 1'b0;
    repeat (8) tick();
    checks++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFF8 || acc_q[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %0d accepts, expected FFFFFFF8 then 00000000", acc_q.size());
    end
    checks++;
    if (del_q.size() < 2 || del_q[0] !== 32'hFFFF_FFF8 || del_q[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_deliver got %0d deliveries, expected FFFFFFF8 then 00000000", del_q.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    lat = 4;
    release_reset();
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    redir_s = 1'b1; redir_pc_s = 32'h0000_3000;
    tick();
    redir_s = 1'b0;
    for (int i = 0; i < 20 && pend.size() != 1; i++) tick();
    @(posedge clk);
    #2;
    checks++;
    if (icache_req_val !== 1'b0 || icache_req_addr !== 32'h3000) begin
      errors++;
      $display("FAIL middrain_state got val=%b addr=%h, expected 0 / 00003000", icache_req_val, icache_req_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (icache_req_val !== 1'b0 || icache_dout_val !== 1'b0 || pc !== 32'h0 ||
        icache_dout !== 64'h0 || icache_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got req_val=%b dout_val=%b pc=%h dout=%h addr=%h, expected all 0",
               icache_req_val, icache_dout_val, pc, icache_dout, icache_req_addr);
    end
    apply_reset();
    release_reset();
    tick();
    tick();
    checks++;
    if (obs_req_val !== 1'b1 || obs_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL restart_pc got val=%b addr=%h, expected 1 / 00000000", obs_req_val, obs_req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collide();
    test_wrap();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
